dcache_controller: RTL and testbench
====================================

DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 Parameter ADDR_W, 32, CPU/memory byte-address width.
REQ-002 Parameter LINE_W, 256, cache line width in bits (32 bytes).
REQ-003 Parameter IDX_W, 4, set index width (16 sets).
REQ-004 clk_i  in  1  single clock, all state on rising edge.
REQ-005 rst_i  in  1  synchronous, active-low reset.
REQ-006 cpu_addr_i  in  32  byte address: tag [31:9], index [8:5], offset [4:0]; word select = [4:2].
REQ-007 cpu_data_i  in  32  store data; cpu_MemRead_i / cpu_MemWrite_i  in  1  request strobes.
REQ-008 cpu_data_o  out  32  load data; cpu_stall_o  out  1  request not yet complete.
REQ-009 sram_addr_o  out  4  set index; sram_tag_o  out  25  {valid[24], dirty[23], tag[22:0]}; sram_data_o  out  256  line.
REQ-010 sram_enable_o, sram_write_o  out  1  SRAM access and write strobes.
REQ-011 sram_tag_i  in  25, sram_data_i  in  256, sram_hit_i  in  1: hit line, or LRU victim line on miss.
REQ-012 mem_addr_o  out  32, mem_data_o  out  256, mem_enable_o  out  1, mem_write_o  out  1: line-memory request.
REQ-013 mem_data_i  in  256, mem_ack_i  in  1: memory response.

Function
REQ-014 Request = cpu_MemRead_i | cpu_MemWrite_i; both high is a write; CPU holds inputs stable while cpu_stall_o=1.
REQ-015 FSM states: IDLE, MISS, WRITEBACK, READMISS, READMISSOK.
REQ-016 sram_addr_o = cpu_addr_i[8:5] and sram_enable_o = request in every state.
REQ-017 IDLE, read hit: cpu_data_o = sram_data_i word [4:2], cpu_stall_o=0 same cycle (zero-cycle hit).
REQ-018 IDLE, write hit: sram_write_o=1, sram_data_o = sram_data_i with word [4:2] replaced by cpu_data_i, sram_tag_o = {1,1,cpu tag}, cpu_stall_o=0.
REQ-019 IDLE, request and no hit: cpu_stall_o=1, next state MISS.
REQ-020 MISS: if sram_tag_i[24] and sram_tag_i[23] (dirty victim): issue write, mem_addr_o = {sram_tag_i[22:0], index, 5'b0}, mem_data_o = sram_data_i; next WRITEBACK. Otherwise issue read at {cpu tag, index, 5'b0}; next READMISS.
REQ-021 Memory request: mem_enable_o high exactly one cycle; mem_addr_o, mem_data_o, mem_write_o registered and held until mem_ack_i; mem_ack_i in the issue cycle ignored.
REQ-022 WRITEBACK: on mem_ack_i issue refill read, next READMISS; otherwise hold.
REQ-023 READMISS: on mem_ack_i, sram_write_o=1, sram_data_o = mem_data_i, sram_tag_o = {1,0,cpu tag}; next READMISSOK; otherwise hold.
REQ-024 READMISSOK: cpu_stall_o=1, no writes; next IDLE, where the access re-executes as a hit.
REQ-025 cpu_stall_o = 1 whenever request is high and state != IDLE.
REQ-026 No request in IDLE: all strobes 0, cpu_stall_o=0, cpu_data_o = 0.
REQ-027 Unexpected mem_ack_i in IDLE, MISS or READMISSOK is ignored.

Reset
REQ-028 rst_i=0 at a clock edge: state IDLE, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
REQ-029 While rst_i=0: cpu_stall_o, sram_enable_o, sram_write_o forced 0, cpu_data_o = 0.
REQ-030 Reset mid-miss abandons the memory transaction; a late mem_ack_i is ignored per REQ-027.

Structure
REQ-031 Package dcache_pkg holds the FSM state enum, index/offset/tag field widths, and tag bit positions VALID_BIT=24, DIRTY_BIT=23.
REQ-032 One sub-module, dcache_word_merge: combinational word extract/insert on a 256-bit line by 3-bit word select.

Verification
REQ-033 Cold read 0x0000_0120, clean victim -> stall; mem read at 0x0000_0120; ack after 10 cycles; SRAM written tag {1,0,0x000000}; hit in IDLE returns refilled word 0.
REQ-034 Read hit, line word 3 = 0xDEADBEEF, addr 0x...0C -> cpu_data_o=0xDEADBEEF, stall 0, no mem_enable_o.
REQ-035 Write hit 0x12345678 at offset 0x04 -> one sram_write_o; only word 1 changed; tag dirty=1.
REQ-036 Miss with victim tag {1,1,0x000005}, index 2 -> mem write at 0x0000_0A40 with victim data, then read at cpu address; exactly two mem_enable_o pulses.
REQ-037 rst_i=0 during READMISS, then ack -> no SRAM write, stall 0, state IDLE.
REQ-038 MemRead and MemWrite both high on a hit -> treated as write per REQ-018.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and field geometry for the direct-mapped-view data cache controller.
// The SRAM tag word is {valid, dirty, tag}.
package dcache_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LINE_W = 256;
    localparam int DEF_IDX_W  = 4;

    localparam int OFFSET_W   = 5;
    localparam int TAG_W      = DEF_ADDR_W - DEF_IDX_W - OFFSET_W;
    localparam int WORD_W     = 32;
    localparam int WORD_SEL_W = 3;
    localparam int SRAM_TAG_W = TAG_W + 2;

    localparam int VALID_BIT  = 24;
    localparam int DIRTY_BIT  = 23;

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        READMISS,
        READMISSOK
    } state_t;

endpackage

// File: rtl/dcache_if.sv
// Bundles the CPU, tag/data SRAM and line-memory signals seen by the cache controller.
// The controller uses the slave view; the surrounding system drives the master view.
interface dcache_if
    import dcache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W,
    parameter int IDX_W  = DEF_IDX_W
);

    logic [ADDR_W-1:0]     cpu_addr_i;
    logic [WORD_W-1:0]     cpu_data_i;
    logic                  cpu_MemRead_i;
    logic                  cpu_MemWrite_i;
    logic [WORD_W-1:0]     cpu_data_o;
    logic                  cpu_stall_o;

    logic [IDX_W-1:0]      sram_addr_o;
    logic [SRAM_TAG_W-1:0] sram_tag_o;
    logic [LINE_W-1:0]     sram_data_o;
    logic                  sram_enable_o;
    logic                  sram_write_o;
    logic [SRAM_TAG_W-1:0] sram_tag_i;
    logic [LINE_W-1:0]     sram_data_i;
    logic                  sram_hit_i;

    logic [ADDR_W-1:0]     mem_addr_o;
    logic [LINE_W-1:0]     mem_data_o;
    logic                  mem_enable_o;
    logic                  mem_write_o;
    logic [LINE_W-1:0]     mem_data_i;
    logic                  mem_ack_i;

    modport slave (
        input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
        output cpu_data_o, cpu_stall_o,
        output sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
        input  sram_tag_i, sram_data_i, sram_hit_i,
        output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
        input  mem_data_i, mem_ack_i
    );

    modport master (
        output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
        input  cpu_data_o, cpu_stall_o,
        input  sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
        output sram_tag_i, sram_data_i, sram_hit_i,
        input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
        output mem_data_i, mem_ack_i
    );

endinterface

// File: rtl/dcache_word_merge.sv
// Combinational 32-bit word extract and word insert on a cache line, selected by word index.
module dcache_word_merge
    import dcache_pkg::*;
#(
    parameter int LINE_W = DEF_LINE_W
) (
    input  logic [LINE_W-1:0]     i_line,
    input  logic [WORD_SEL_W-1:0] i_sel,
    input  logic [WORD_W-1:0]     i_word,
    output logic [WORD_W-1:0]     o_word,
    output logic [LINE_W-1:0]     o_line
);

    always_comb begin
        o_word = i_line[i_sel*WORD_W +: WORD_W];
        o_line = i_line;
        o_line[i_sel*WORD_W +: WORD_W] = i_word;
    end

endmodule

// File: rtl/dcache_controller.sv
// Write-back data cache controller: zero-cycle hits, dirty-victim writeback, then line refill.
// After a refill the access re-executes in IDLE as an ordinary hit.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W,
    parameter int IDX_W  = DEF_IDX_W
) (
    input  logic     clk_i,
    input  logic     rst_i,
    dcache_if.slave  bus
);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_mem_enable;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [LINE_W-1:0]   r_mem_data;

    logic                w_req;
    logic                w_write;
    logic                w_ack;
    logic                w_victim_dirty;
    logic [TAG_W-1:0]    w_cpu_tag;
    logic [IDX_W-1:0]    w_index;
    logic [WORD_SEL_W-1:0] w_word_sel;
    logic [WORD_W-1:0]   w_hit_word;
    logic [LINE_W-1:0]   w_merged_line;
    logic                w_issue;
    logic                w_issue_write;
    logic [ADDR_W-1:0]   w_issue_addr;
    logic [LINE_W-1:0]   w_issue_data;
    logic                w_unused;

    assign w_req          = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
    assign w_write        = bus.cpu_MemWrite_i;
    assign w_cpu_tag      = bus.cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign w_index        = bus.cpu_addr_i[OFFSET_W +: IDX_W];
    assign w_word_sel     = bus.cpu_addr_i[2 +: WORD_SEL_W];
    assign w_victim_dirty = bus.sram_tag_i[VALID_BIT] & bus.sram_tag_i[DIRTY_BIT];
    // An ack arriving in the same cycle the request is presented belongs to nothing we issued.
    assign w_ack          = bus.mem_ack_i & ~r_mem_enable;
    assign w_unused       = ^bus.cpu_addr_i[1:0];

    assign bus.sram_addr_o  = w_index;
    assign bus.mem_addr_o   = r_mem_addr;
    assign bus.mem_data_o   = r_mem_data;
    assign bus.mem_enable_o = r_mem_enable;
    assign bus.mem_write_o  = r_mem_write;

    dcache_word_merge #(
        .LINE_W (LINE_W)
    ) u_word_merge (
        .i_line (bus.sram_data_i),
        .i_sel  (w_word_sel),
        .i_word (bus.cpu_data_i),
        .o_word (w_hit_word),
        .o_line (w_merged_line)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state      <= IDLE;
            r_mem_enable <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
        end else begin
            r_state      <= w_next_state;
            r_mem_enable <= w_issue;
            if (w_issue) begin
                r_mem_write <= w_issue_write;
                r_mem_addr  <= w_issue_addr;
                r_mem_data  <= w_issue_data;
            end
        end
    end

    always_comb begin
        w_next_state      = r_state;
        w_issue           = 1'b0;
        w_issue_write     = 1'b0;
        w_issue_addr      = '0;
        w_issue_data      = '0;
        bus.cpu_stall_o   = 1'b0;
        bus.cpu_data_o    = '0;
        bus.sram_enable_o = w_req;
        bus.sram_write_o  = 1'b0;
        bus.sram_tag_o    = '0;
        bus.sram_data_o   = '0;

        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (bus.sram_hit_i) begin
                        if (w_write) begin
                            bus.sram_write_o = 1'b1;
                            bus.sram_data_o  = w_merged_line;
                            bus.sram_tag_o   = {1'b1, 1'b1, w_cpu_tag};
                        end else begin
                            bus.cpu_data_o = w_hit_word;
                        end
                    end else begin
                        bus.cpu_stall_o = 1'b1;
                        w_next_state    = MISS;
                    end
                end
            end
            MISS: begin
                bus.cpu_stall_o = w_req;
                w_issue         = 1'b1;
                if (w_victim_dirty) begin
                    w_issue_write = 1'b1;
                    w_issue_addr  = {bus.sram_tag_i[TAG_W-1:0], w_index, {OFFSET_W{1'b0}}};
                    w_issue_data  = bus.sram_data_i;
                    w_next_state  = WRITEBACK;
                end else begin
                    w_issue_addr  = {w_cpu_tag, w_index, {OFFSET_W{1'b0}}};
                    w_next_state  = READMISS;
                end
            end
            WRITEBACK: begin
                bus.cpu_stall_o = w_req;
                if (w_ack) begin
                    w_issue      = 1'b1;
                    w_issue_addr = {w_cpu_tag, w_index, {OFFSET_W{1'b0}}};
                    w_next_state = READMISS;
                end
            end
            READMISS: begin
                bus.cpu_stall_o = w_req;
                if (w_ack) begin
                    bus.sram_write_o = 1'b1;
                    bus.sram_data_o  = bus.mem_data_i;
                    bus.sram_tag_o   = {1'b1, 1'b0, w_cpu_tag};
                    w_next_state     = READMISSOK;
                end
            end
            READMISSOK: begin
                bus.cpu_stall_o = w_req;
                w_next_state    = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        if (!rst_i) begin
            bus.cpu_stall_o   = 1'b0;
            bus.cpu_data_o    = '0;
            bus.sram_enable_o = 1'b0;
            bus.sram_write_o  = 1'b0;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed-vector bench for dcache_controller; the SRAM and line memory are played by hand per vector.
module tb_dcache_controller;
    import dcache_pkg::*;

    localparam logic [255:0] LINE_A = {32'h7070_7070, 32'h6060_6060, 32'h5050_5050, 32'h4040_4040,
                                       32'hDEAD_BEEF, 32'h2020_2020, 32'h1010_1010, 32'h0000_0C0C};
    localparam logic [255:0] LINE_A_W1 = {32'h7070_7070, 32'h6060_6060, 32'h5050_5050, 32'h4040_4040,
                                          32'hDEAD_BEEF, 32'h2020_2020, 32'h1234_5678, 32'h0000_0C0C};
    localparam logic [255:0] LINE_A_W7 = {32'hCAFE_F00D, 32'h6060_6060, 32'h5050_5050, 32'h4040_4040,
                                          32'hDEAD_BEEF, 32'h2020_2020, 32'h1010_1010, 32'h0000_0C0C};
    localparam logic [255:0] LINE_R = {32'h8888_0007, 32'h8888_0006, 32'h8888_0005, 32'h8888_0004,
                                       32'h8888_0003, 32'h8888_0002, 32'h8888_0001, 32'h8888_0000};
    localparam logic [255:0] LINE_B = {32'hB000_0007, 32'hB000_0006, 32'hB000_0005, 32'hB000_0004,
                                       32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
    localparam logic [255:0] LINE_C = {32'hC000_0007, 32'hC000_0006, 32'hC000_0005, 32'hC000_0004,
                                       32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000};

    logic clk = 1'b0;
    logic rstN;
    int   vectorCount     = 0;
    int   miscompareCount = 0;
    int   memPulseCount   = 0;
    int   pulseBase;

    dcache_if bus ();

    dcache_controller dut (
        .clk_i (clk),
        .rst_i (rstN),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_enable_o === 1'b1) memPulseCount++;
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        bus.cpu_MemRead_i  = rd;
        bus.cpu_MemWrite_i = wr;
        bus.cpu_addr_i     = addr;
        bus.cpu_data_i     = wdata;
    endtask

    task automatic setSram(input logic hit, input logic [24:0] tag, input logic [255:0] line);
        bus.sram_hit_i  = hit;
        bus.sram_tag_i  = tag;
        bus.sram_data_i = line;
    endtask

    initial begin
        rstN          = 1'b0;
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        applyStimulus(1'b1, 1'b0, 32'h0000_0120, 32'h0);
        setSram(1'b0, 25'h0, LINE_B);
        tick();
        tick();
        checkOutput("reset_stall", bus.cpu_stall_o, 1'b0);
        checkOutput("reset_sram_enable", bus.sram_enable_o, 1'b0);
        checkOutput("reset_sram_write", bus.sram_write_o, 1'b0);
        checkOutput("reset_cpu_data", bus.cpu_data_o, 32'h0);
        checkOutput("reset_mem_enable", bus.mem_enable_o, 1'b0);
        checkOutput("reset_mem_write", bus.mem_write_o, 1'b0);
        checkOutput("reset_mem_addr", bus.mem_addr_o, 32'h0);

        rstN = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        setSram(1'b1, 25'h1000000, LINE_A);
        #1;
        checkOutput("idle_noreq_stall", bus.cpu_stall_o, 1'b0);
        checkOutput("idle_noreq_sram_enable", bus.sram_enable_o, 1'b0);
        checkOutput("idle_noreq_cpu_data", bus.cpu_data_o, 32'h0);

        // Read hits on word 3 and word 7.
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0000_000C, 32'h0);
        #1;
        checkOutput("rdhit_data", bus.cpu_data_o, 32'hDEAD_BEEF);
        checkOutput("rdhit_stall", bus.cpu_stall_o, 1'b0);
        checkOutput("rdhit_sram_enable", bus.sram_enable_o, 1'b1);
        checkOutput("rdhit_sram_write", bus.sram_write_o, 1'b0);
        tick();
        checkOutput("rdhit_no_mem", bus.mem_enable_o, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0000_001C, 32'h0);
        #1;
        checkOutput("rdhit_w7_data", bus.cpu_data_o, 32'h7070_7070);

        // Write hit at tag 1, index 2, offset 4.
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0000_0244, 32'h1234_5678);
        #1;
        checkOutput("wrhit_sram_write", bus.sram_write_o, 1'b1);
        checkOutput("wrhit_sram_addr", bus.sram_addr_o, 4'h2);
        checkOutput("wrhit_line", bus.sram_data_o, LINE_A_W1);
        checkOutput("wrhit_tag", bus.sram_tag_o, 25'h1800001);
        checkOutput("wrhit_stall", bus.cpu_stall_o, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("wrhit_single_write", bus.sram_write_o, 1'b0);
        checkOutput("wrhit_no_mem", bus.mem_enable_o, 1'b0);

        // Both strobes high on a hit behaves as a write.
        tick();
        applyStimulus(1'b1, 1'b1, 32'h0000_001C, 32'hCAFE_F00D);
        #1;
        checkOutput("rdwr_sram_write", bus.sram_write_o, 1'b1);
        checkOutput("rdwr_line", bus.sram_data_o, LINE_A_W7);
        checkOutput("rdwr_tag", bus.sram_tag_o, 25'h1800000);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

        // Cold read miss with a clean (invalid) victim, refill after 10 cycles.
        tick();
        pulseBase = memPulseCount;
        applyStimulus(1'b1, 1'b0, 32'h0000_0120, 32'h0);
        setSram(1'b0, 25'h0, LINE_B);
        #1;
        checkOutput("cold_idle_stall", bus.cpu_stall_o, 1'b1);
        checkOutput("cold_sram_addr", bus.sram_addr_o, 4'h9);
        tick();
        checkOutput("cold_miss_stall", bus.cpu_stall_o, 1'b1);
        checkOutput("cold_miss_no_issue_yet", bus.mem_enable_o, 1'b0);
        tick();
        bus.mem_ack_i = 1'b1;
        #1;
        checkOutput("cold_issue_enable", bus.mem_enable_o, 1'b1);
        checkOutput("cold_issue_addr", bus.mem_addr_o, 32'h0000_0120);
        checkOutput("cold_issue_write", bus.mem_write_o, 1'b0);
        checkOutput("cold_issue_ack_ignored", bus.sram_write_o, 1'b0);
        tick();
        bus.mem_ack_i = 1'b0;
        #1;
        checkOutput("cold_enable_one_cycle", bus.mem_enable_o, 1'b0);
        checkOutput("cold_addr_held", bus.mem_addr_o, 32'h0000_0120);
        for (int i = 0; i < 8; i++) tick();
        bus.mem_ack_i  = 1'b1;
        bus.mem_data_i = LINE_R;
        #1;
        checkOutput("cold_refill_write", bus.sram_write_o, 1'b1);
        checkOutput("cold_refill_tag", bus.sram_tag_o, 25'h1000000);
        checkOutput("cold_refill_line", bus.sram_data_o, LINE_R);
        checkOutput("cold_refill_stall", bus.cpu_stall_o, 1'b1);
        tick();
        bus.mem_ack_i = 1'b0;
        #1;
        checkOutput("cold_ok_stall", bus.cpu_stall_o, 1'b1);
        checkOutput("cold_ok_no_write", bus.sram_write_o, 1'b0);
        tick();
        setSram(1'b1, 25'h1000000, LINE_R);
        #1;
        checkOutput("cold_rehit_stall", bus.cpu_stall_o, 1'b0);
        checkOutput("cold_rehit_data", bus.cpu_data_o, 32'h8888_0000);
        checkOutput("cold_pulses", memPulseCount - pulseBase, 1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

        // Miss on index 2 with a dirty victim of tag 5: writeback then refill.
        tick();
        pulseBase = memPulseCount;
        applyStimulus(1'b1, 1'b0, 32'h0000_0E48, 32'h0);
        setSram(1'b0, 25'h1800005, LINE_B);
        #1;
        checkOutput("dirty_idle_stall", bus.cpu_stall_o, 1'b1);
        tick();
        tick();
        checkOutput("dirty_wb_enable", bus.mem_enable_o, 1'b1);
        checkOutput("dirty_wb_write", bus.mem_write_o, 1'b1);
        checkOutput("dirty_wb_addr", bus.mem_addr_o, 32'h0000_0A40);
        checkOutput("dirty_wb_data", bus.mem_data_o, LINE_B);
        tick();
        bus.mem_ack_i = 1'b1;
        #1;
        checkOutput("dirty_wb_no_sram_write", bus.sram_write_o, 1'b0);
        tick();
        bus.mem_ack_i = 1'b0;
        #1;
        checkOutput("dirty_rd_enable", bus.mem_enable_o, 1'b1);
        checkOutput("dirty_rd_write", bus.mem_write_o, 1'b0);
        checkOutput("dirty_rd_addr", bus.mem_addr_o, 32'h0000_0E40);
        tick();
        bus.mem_ack_i  = 1'b1;
        bus.mem_data_i = LINE_C;
        #1;
        checkOutput("dirty_refill_write", bus.sram_write_o, 1'b1);
        checkOutput("dirty_refill_tag", bus.sram_tag_o, 25'h1000007);
        tick();
        bus.mem_ack_i = 1'b0;
        tick();
        setSram(1'b1, 25'h1000007, LINE_C);
        #1;
        checkOutput("dirty_rehit_data", bus.cpu_data_o, 32'hC000_0002);
        checkOutput("dirty_rehit_stall", bus.cpu_stall_o, 1'b0);
        checkOutput("dirty_pulses", memPulseCount - pulseBase, 2);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset in the middle of a refill abandons it; the late ack is dropped.
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0000_0300, 32'h0);
        setSram(1'b0, 25'h0, LINE_B);
        tick();
        tick();
        tick();
        rstN           = 1'b0;
        bus.mem_ack_i  = 1'b1;
        bus.mem_data_i = LINE_R;
        #1;
        checkOutput("rstmid_no_sram_write", bus.sram_write_o, 1'b0);
        checkOutput("rstmid_stall", bus.cpu_stall_o, 1'b0);
        tick();
        rstN = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("rstmid_mem_enable", bus.mem_enable_o, 1'b0);
        checkOutput("rstmid_late_ack_write", bus.sram_write_o, 1'b0);
        tick();
        checkOutput("rstmid_no_reissue", bus.mem_enable_o, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0000_000C, 32'h0);
        setSram(1'b1, 25'h1000000, LINE_A);
        #1;
        checkOutput("rstmid_idle_hit_stall", bus.cpu_stall_o, 1'b0);
        checkOutput("rstmid_idle_hit_data", bus.cpu_data_o, 32'hDEAD_BEEF);
        checkOutput("rstmid_idle_ack_ignored", bus.sram_write_o, 1'b0);
        tick();
        bus.mem_ack_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
